wave_fetch_sequencer: RTL
=========================

Name: wave_fetch_sequencer

Overview:
- Per-wavefront fetch-side producer for the wavepool instruction queue.
- Issues instruction-fetch requests toward the fetch unit while the queue controller's stop_fetch is low, and pulses q_vtail_incr to reserve a slot for each accepted request.
- Writes returning instructions into the queue with q_wr, and discards stale returns after a branch redirect using a 1-bit epoch.
- On wave start or redirect, resets the queue through q_reset.

Parameters:
PC_WIDTH, 32, program counter width
INSTR_BYTES, 4, PC increment per accepted fetch
MAX_OUTSTANDING, 6, cap on in-flight requests; must be <= 7

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
wave_start  input  1  begin fetching a new wavefront; honoured only in IDLE
wave_start_pc  input  PC_WIDTH  initial PC, sampled with wave_start
wave_halt  input  1  end of program; stop issuing and drain
branch_taken  input  1  redirect pulse
branch_target  input  PC_WIDTH  redirect PC
stop_fetch  input  1  queue nearly full, from queue controller
q_vtail_incr  output  1  reserve a queue slot
q_wr  output  1  write a returned instruction into the queue
q_reset  output  1  clear the queue pointers
fetch_req_valid  output  1  fetch request valid
fetch_req_pc  output  PC_WIDTH  request address
fetch_req_epoch  output  1  epoch tag carried with the request
fetch_req_ready  input  1  fetch unit accepts the request
fetch_rsp_valid  input  1  fetch return
fetch_rsp_epoch  input  1  epoch of the return
outstanding  output  3  number of in-flight requests
wave_fetch_done  output  1  one-cycle pulse when the drain completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the clk rising edge.
- Reset values:
  - state=IDLE, pc=0, epoch=0, outstanding=0.
  - All 1-bit outputs are 0. fetch_req_pc=0.
- Registered state: state {IDLE, RUN, DRAIN}, pc, epoch, outstanding.
- All outputs are combinational from registered state plus the current inputs. There is no added latency.
- fetch_req_valid = (state==RUN) & ~stop_fetch & ~branch_taken & ~wave_halt & (outstanding < MAX_OUTSTANDING).
- fetch_req_pc = pc. fetch_req_epoch = epoch.
- Accept (fetch_req_valid & fetch_req_ready):
  - q_vtail_incr=1 in the same cycle.
  - pc <= pc + INSTR_BYTES, wrapping modulo 2^PC_WIDTH.
  - outstanding is incremented.
- Valid may deassert without ready only because of branch_taken, wave_halt or rst. Otherwise it is held with a stable pc until accepted.
- Return (fetch_rsp_valid):
  - Always decrements outstanding. An accept and a return in the same cycle leave outstanding unchanged.
  - A return while outstanding==0 is ignored; the counter does not underflow.
  - q_wr=1 iff fetch_rsp_epoch==epoch, state!=IDLE, and there is no branch_taken or wave_start in that cycle.
- IDLE:
  - wave_start=1: q_reset=1, pc <= wave_start_pc, epoch toggles, next state RUN.
  - Other inputs are ignored.
- RUN:
  - branch_taken=1: q_reset=1, no request issued, pc <= branch_target, epoch toggles, stay in RUN. Fetching resumes the next cycle.
  - wave_halt=1 (wave_halt wins if asserted with branch_taken): no request issued, next state DRAIN.
- DRAIN:
  - No requests are issued. Current-epoch returns are still written.
  - When the post-update outstanding==0, go to IDLE and pulse wave_fetch_done for one cycle. If outstanding is already 0 on halt, DRAIN lasts one cycle.
- rst mid-operation returns to reset values immediately. The bench treats returns for pre-reset requests as ignored.

Decomposition:
- Shared wavepool package holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - the INSTR_BYTES default;
  - the 3-bit queue depth constant shared with the queue controller.
- One sub-module: fetch_outstanding_ctr. It is a 3-bit saturating up/down counter with inc/dec inputs, simultaneous-event handling and an at-max flag.

Test Plan:
1. rst, then wave_start with pc=0x100, fetch_req_ready=1, stop_fetch=0 -> requests at 0x100, 0x104, 0x108…; q_vtail_incr each cycle; outstanding stops at 6 with valid low.
2. stop_fetch=1 in RUN, then drop it -> valid is 0 while stop_fetch is high; the next request is at the held pc with no skipped address.
3. Three requests with epoch=1 outstanding, then branch_taken to 0x400 -> q_reset=1 for one cycle; epoch becomes 0; the three epoch-1 returns give q_wr=0 and outstanding falls to 0; the next request is at 0x400.
4. fetch_req_ready=0 for 5 cycles -> valid and pc stay stable; no q_vtail_incr until ready=1.
5. wave_halt with 2 outstanding, returns arriving 3 cycles apart -> two q_wr pulses; wave_fetch_done pulses in the cycle of the second return; state becomes IDLE.
6. Accept and return in the same cycle at outstanding=3 -> outstanding stays 3; q_vtail_incr and q_wr are both 1.

Source files
------------

// File: rtl/wave_fetch_sequencer_pkg.sv
// Shared wavepool definitions used by the fetch sequencer and the queue controller.
//   - wfs_state_e   : fetch sequencer state encoding
//   - InstrBytes    : default PC increment per fetched instruction
//   - OutstandingW  : width of the in-flight request counter
//   - QDepth        : 3-bit queue depth constant shared with the queue controller
package wave_fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } wfs_state_e;

  localparam int unsigned InstrBytes   = 4;
  localparam int unsigned OutstandingW = 3;
  localparam logic [OutstandingW-1:0] QDepth = 3'd7;

endpackage

// File: rtl/wave_fetch_sequencer_outstanding_ctr.sv
// fetch_outstanding_ctr: saturating up/down counter of in-flight fetch requests.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   inc_i, dec_i  - request accepted / response returned this cycle
//   count_o       - current count
//   count_next_o  - count after this cycle's update
//   at_max_o      - count has reached MaxVal
module fetch_outstanding_ctr
  import wave_fetch_sequencer_pkg::*;
#(
  parameter int unsigned MaxVal = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc_i,
  input  logic                    dec_i,
  output logic [OutstandingW-1:0] count_o,
  output logic [OutstandingW-1:0] count_next_o,
  output logic                    at_max_o
);

  localparam logic [OutstandingW-1:0] MaxCnt = OutstandingW'(MaxVal);

  logic [OutstandingW-1:0] count_q, count_d;
  logic                    inc_ok, dec_ok;

  always_comb begin
    // Saturate at both ends; a decrement at zero is dropped, so an
    // increment in the same cycle still takes effect.
    inc_ok  = inc_i && (count_q != MaxCnt);
    dec_ok  = dec_i && (count_q != '0);
    count_d = count_q;
    unique case ({inc_ok, dec_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign at_max_o     = (count_q == MaxCnt);

endmodule

// File: rtl/wave_fetch_sequencer.sv
// Per-wavefront fetch producer for the wavepool instruction queue.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   wave_start, wave_start_pc     - launch a wavefront (IDLE only)
//   wave_halt                     - stop issuing and drain in-flight requests
//   branch_taken, branch_target   - redirect; bumps the epoch and clears the queue
//   stop_fetch                    - queue nearly full
//   q_vtail_incr, q_wr, q_reset   - queue slot reserve / write / pointer clear
//   fetch_req_*                   - request handshake toward the fetch unit
//   fetch_rsp_valid/epoch         - instruction return
//   outstanding                   - in-flight request count
//   wave_fetch_done               - one-cycle pulse when the drain completes
module wave_fetch_sequencer
  import wave_fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_WIDTH        = 32,
  parameter int unsigned INSTR_BYTES     = InstrBytes,
  parameter int unsigned MAX_OUTSTANDING = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wave_start,
  input  logic [PC_WIDTH-1:0] wave_start_pc,
  input  logic                wave_halt,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                stop_fetch,
  output logic                q_vtail_incr,
  output logic                q_wr,
  output logic                q_reset,
  output logic                fetch_req_valid,
  output logic [PC_WIDTH-1:0] fetch_req_pc,
  output logic                fetch_req_epoch,
  input  logic                fetch_req_ready,
  input  logic                fetch_rsp_valid,
  input  logic                fetch_rsp_epoch,
  output logic [2:0]          outstanding,
  output logic                wave_fetch_done
);

  wfs_state_e              state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic                    epoch_q, epoch_d;
  logic [OutstandingW-1:0] cnt, cnt_next;
  logic                    at_max, accept, q_reset_c, done_c;

  fetch_outstanding_ctr #(
    .MaxVal(MAX_OUTSTANDING)
  ) u_ctr (
    .clk         (clk),
    .rst         (rst),
    .inc_i       (accept),
    .dec_i       (fetch_rsp_valid),
    .count_o     (cnt),
    .count_next_o(cnt_next),
    .at_max_o    (at_max)
  );

  // Outputs are forced to their reset values while rst is high so a reset
  // mid-operation takes effect in the same cycle.
  always_comb begin
    fetch_req_valid = !rst && (state_q == StRun) && !stop_fetch && !branch_taken &&
                      !wave_halt && !at_max;
    accept          = fetch_req_valid && fetch_req_ready;
    q_vtail_incr    = accept;
    q_wr            = !rst && fetch_rsp_valid && (fetch_rsp_epoch == epoch_q) &&
                      (state_q != StIdle) && !branch_taken && !wave_start;
    fetch_req_pc    = rst ? '0 : pc_q;
    fetch_req_epoch = !rst && epoch_q;
    outstanding     = rst ? '0 : cnt;
    q_reset         = !rst && q_reset_c;
    wave_fetch_done = !rst && done_c;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    epoch_d   = epoch_q;
    q_reset_c = 1'b0;
    done_c    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wave_start) begin
          q_reset_c = 1'b1;
          pc_d      = wave_start_pc;
          epoch_d   = ~epoch_q;
          state_d   = StRun;
        end
      end
      StRun: begin
        // Halt takes priority over a simultaneous redirect.
        if (wave_halt) begin
          state_d = StDrain;
        end else if (branch_taken) begin
          q_reset_c = 1'b1;
          pc_d      = branch_target;
          epoch_d   = ~epoch_q;
        end else if (accept) begin
          pc_d = pc_q + PC_WIDTH'(INSTR_BYTES);
        end
      end
      StDrain: begin
        if (cnt_next == '0) begin
          state_d = StIdle;
          done_c  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

endmodule
